fpu_host_bridge: RTL and testbench

CPU-side initiator for the FPU core. It exposes an 8-bit register window to the Sol-1 CPU bus, assembles two 32-bit operands and an operation code, and drives the FPU core's four-phase start/done/ack handshake. It captures the 32-bit result and raises a completion flag and an optional interrupt. It sits between the CPU I/O decoder and the FPU core's main controller, which idles, waits for the operation to finish, presents the result, then waits for ack.

---
 rtl/fpu_host_bridge_if.sv | 33 +++
 rtl/fpu_host_bridge.sv | 182 ++++++++++++++++++
 tb/tb_fpu_host_bridge.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fpu_host_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_host_bridge_if
// Brief    : CPU register-window bus plus FPU core start/done/ack handshake.
//            master = bridge side, slave = CPU decoder / FPU core side.
// Revision : 1.0 - initial release
// ============================================================================
interface fpu_host_bridge_if;
    logic [3:0]  cpu_addr;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_irq;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [3:0]  fpu_op;
    logic        fpu_start;
    logic        fpu_done;
    logic [31:0] fpu_result;
    logic        fpu_ack;

    modport master (
        input  cpu_addr, cpu_wr, cpu_rd, cpu_wdata, fpu_done, fpu_result,
        output cpu_rdata, cpu_irq, fpu_a, fpu_b, fpu_op, fpu_start, fpu_ack
    );

    modport slave (
        output cpu_addr, cpu_wr, cpu_rd, cpu_wdata, fpu_done, fpu_result,
        input  cpu_rdata, cpu_irq, fpu_a, fpu_b, fpu_op, fpu_start, fpu_ack
    );
endinterface
`default_nettype wire

// File: rtl/fpu_host_bridge.sv
`default_nettype none
// ============================================================================
// Module   : fpu_host_bridge
// Brief    : CPU-side initiator for the FPU core. Byte-wide register window
//            for operands/op/status/result, four-phase start/done/ack
//            handshake, cycle counter, completion flag and interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_host_bridge #(
    parameter logic [3:0] OP_MAX = 4'hC
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fpu_host_bridge_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_ACK       = 3'd3,
        S_RELEASE   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] result_q, result_d;
    logic [3:0]  op_q, op_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        irq_en_q, irq_en_d;
    logic        start_q, start_d;
    logic        ack_q, ack_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        w_busy;
    logic        w_go;

    assign w_busy = (state_q != S_IDLE);
    assign w_go   = bus.cpu_wr && (bus.cpu_addr == 4'h9);

    // Next-state: register writes first, then the FSM so its flag updates
    // (go clearing done, RELEASE setting done) take priority.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        op_d     = op_q;
        done_d   = done_q;
        err_d    = err_q;
        irq_en_d = irq_en_q;
        start_d  = start_q;
        ack_d    = ack_q;
        cnt_d    = cnt_q;

        if (bus.cpu_wr) begin
            // Operand and op registers are frozen while an operation runs
            if (!w_busy) begin
                if (bus.cpu_addr[3:2] == 2'b00) begin
                    a_d[{bus.cpu_addr[1:0], 3'b000} +: 8] = bus.cpu_wdata;
                end else if (bus.cpu_addr[3:2] == 2'b01) begin
                    b_d[{bus.cpu_addr[1:0], 3'b000} +: 8] = bus.cpu_wdata;
                end else if (bus.cpu_addr == 4'h8) begin
                    op_d = bus.cpu_wdata[3:0];
                end
            end
            if (bus.cpu_addr == 4'hA) begin
                irq_en_d = bus.cpu_wdata[2];
                if (bus.cpu_wdata[1]) done_d = 1'b0;
                if (bus.cpu_wdata[3]) err_d  = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (w_go) begin
                    if (op_q > OP_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        done_d  = 1'b0;
                        cnt_d   = 8'h00;
                        start_d = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // fpu_done is deliberately ignored here
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.fpu_done) begin
                    result_d = bus.fpu_result;
                    start_d  = 1'b0;
                    ack_d    = 1'b1;
                    state_d  = S_ACK;
                end
            end
            S_ACK: begin
                if (!bus.fpu_done) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                ack_d   = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                start_d = 1'b0;
                ack_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Saturating latency counter over the active handshake phases
        if ((state_q == S_REQ || state_q == S_WAIT_DONE || state_q == S_ACK)
            && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Read mux: captures pre-write register values, holds between reads
    always_comb begin
        rdata_d = rdata_q;
        if (bus.cpu_rd) begin
            case (bus.cpu_addr)
                4'h0, 4'h1, 4'h2, 4'h3: rdata_d = a_q[{bus.cpu_addr[1:0], 3'b000} +: 8];
                4'h4, 4'h5, 4'h6, 4'h7: rdata_d = b_q[{bus.cpu_addr[1:0], 3'b000} +: 8];
                4'h8:                   rdata_d = {4'h0, op_q};
                4'hA:                   rdata_d = {4'h0, err_q, irq_en_q, done_q, w_busy};
                4'hB:                   rdata_d = cnt_q;
                4'hC, 4'hD, 4'hE, 4'hF: rdata_d = result_q[{bus.cpu_addr[1:0], 3'b000} +: 8];
                default:                rdata_d = 8'h00;
            endcase
        end
    end

    // State and register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            result_q <= 32'h0;
            op_q     <= 4'h0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            irq_en_q <= 1'b0;
            start_q  <= 1'b0;
            ack_q    <= 1'b0;
            cnt_q    <= 8'h00;
            rdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            op_q     <= op_d;
            done_q   <= done_d;
            err_q    <= err_d;
            irq_en_q <= irq_en_d;
            start_q  <= start_d;
            ack_q    <= ack_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.fpu_a     = a_q;
    assign bus.fpu_b     = b_q;
    assign bus.fpu_op    = op_q;
    assign bus.fpu_start = start_q;
    assign bus.fpu_ack   = ack_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_irq   = done_q & irq_en_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_host_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_host_bridge
// Brief    : Directed testbench for fpu_host_bridge; the FPU core side is
//            driven cycle by cycle from the main stimulus sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_host_bridge;

    logic clk;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    fpu_host_bridge_if bus ();

    fpu_host_bridge #(.OP_MAX(4'hC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [3:0] addr, input logic [7:0] data);
        bus.cpu_addr  = addr;
        bus.cpu_wdata = data;
        bus.cpu_wr    = 1'b1;
        tick();
        bus.cpu_wr    = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] addr, input string tag, input logic [7:0] exp);
        bus.cpu_addr = addr;
        bus.cpu_rd   = 1'b1;
        tick();
        bus.cpu_rd   = 1'b0;
        check(tag, {24'h0, bus.cpu_rdata}, {24'h0, exp});
    endtask

    initial begin
        rst            = 1'b1;
        bus.cpu_addr   = 4'h0;
        bus.cpu_wr     = 1'b0;
        bus.cpu_rd     = 1'b0;
        bus.cpu_wdata  = 8'h00;
        bus.fpu_done   = 1'b0;
        bus.fpu_result = 32'h0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_start", {31'h0, bus.fpu_start}, 32'h0);
        check("rst_ack",   {31'h0, bus.fpu_ack},   32'h0);
        check("rst_irq",   {31'h0, bus.cpu_irq},   32'h0);
        check("rst_a",     bus.fpu_a,              32'h0);
        check("rst_rdata", {24'h0, bus.cpu_rdata}, 32'h0);
        cpu_read(4'hA, "rst_status", 8'h00);

        // Operation 1: 1.0 + 2.0, core answers after 5 cycles of start
        cpu_write(4'h0, 8'h00); cpu_write(4'h1, 8'h00);
        cpu_write(4'h2, 8'h80); cpu_write(4'h3, 8'h3F);
        cpu_write(4'h4, 8'h00); cpu_write(4'h5, 8'h00);
        cpu_write(4'h6, 8'h00); cpu_write(4'h7, 8'h40);
        cpu_write(4'h8, 8'h00);
        check("op1_a",  bus.fpu_a,  32'h3F800000);
        check("op1_b",  bus.fpu_b,  32'h40000000);
        check("op1_op", {28'h0, bus.fpu_op}, 32'h0);
        cpu_write(4'h9, 8'h00);                       // go at T, now T+1
        check("op1_start_t1", {31'h0, bus.fpu_start}, 32'h1);
        tick(); tick(); tick(); tick();               // T+5
        check("op1_start_t5", {31'h0, bus.fpu_start}, 32'h1);
        bus.fpu_done   = 1'b1;
        bus.fpu_result = 32'h40400000;
        tick();                                       // T+6
        check("op1_start_drop", {31'h0, bus.fpu_start}, 32'h0);
        check("op1_ack_rise",   {31'h0, bus.fpu_ack},   32'h1);
        tick();                                       // T+7
        bus.fpu_done   = 1'b0;
        bus.fpu_result = 32'h0;
        check("op1_ack_t7", {31'h0, bus.fpu_ack}, 32'h1);
        tick();                                       // T+8 release
        check("op1_ack_t8", {31'h0, bus.fpu_ack}, 32'h1);
        tick();                                       // T+9
        check("op1_ack_t9", {31'h0, bus.fpu_ack}, 32'h0);
        cpu_read(4'hA, "op1_status", 8'h02);
        cpu_read(4'hC, "op1_res0", 8'h00);
        cpu_read(4'hD, "op1_res1", 8'h00);
        cpu_read(4'hE, "op1_res2", 8'h40);
        cpu_read(4'hF, "op1_res3", 8'h40);
        cpu_read(4'hB, "op1_cycles", 8'h07);
        tick(); tick();
        check("rdata_hold", {24'h0, bus.cpu_rdata}, 32'h07);

        // Illegal op code, plus read-during-write of the op register
        bus.cpu_addr  = 4'h8;
        bus.cpu_wdata = 8'h0D;
        bus.cpu_wr    = 1'b1;
        bus.cpu_rd    = 1'b1;
        tick();
        bus.cpu_wr = 1'b0;
        bus.cpu_rd = 1'b0;
        check("rd_wr_old", {24'h0, bus.cpu_rdata}, 32'h00);
        cpu_read(4'h8, "op_readback", 8'h0D);
        cpu_write(4'h9, 8'h00);
        check("bad_start_t1", {31'h0, bus.fpu_start}, 32'h0);
        tick();
        check("bad_start_t2", {31'h0, bus.fpu_start}, 32'h0);
        cpu_read(4'hA, "bad_status", 8'h0A);
        cpu_write(4'hA, 8'h08);
        cpu_read(4'hA, "err_clear", 8'h02);

        // Operation 2: writes while busy ignored, done-clear collides with set
        cpu_write(4'h8, 8'h00);
        cpu_write(4'h9, 8'h00);                       // T+1
        cpu_write(4'h0, 8'hFF);                       // in REQ, T+2
        check("busy_a", bus.fpu_a, 32'h3F800000);
        cpu_write(4'h9, 8'h00);                       // in WAIT_DONE, T+3
        check("op2_start_t3", {31'h0, bus.fpu_start}, 32'h1);
        tick(); tick();                               // T+5
        bus.fpu_done   = 1'b1;
        bus.fpu_result = 32'h40400000;
        tick();                                       // T+6
        tick();                                       // T+7
        bus.fpu_done   = 1'b0;
        bus.fpu_result = 32'h0;
        tick();                                       // T+8 release
        cpu_write(4'hA, 8'h02);                       // clear vs set, T+9
        check("op2_ack_off", {31'h0, bus.fpu_ack}, 32'h0);
        tick(); tick();
        check("no_second_req", {31'h0, bus.fpu_start}, 32'h0);
        cpu_read(4'hA, "op2_status", 8'h02);
        cpu_read(4'h0, "op2_a0", 8'h00);
        cpu_read(4'hF, "op2_res3", 8'h40);
        cpu_read(4'hB, "op2_cycles", 8'h07);

        // Operation 3: interrupt enabled, core holds done 4 cycles after ack
        cpu_write(4'hA, 8'h06);
        check("irq_pre", {31'h0, bus.cpu_irq}, 32'h0);
        cpu_read(4'hA, "irq_en_status", 8'h04);
        cpu_write(4'h9, 8'h00);                       // T+1
        tick();                                       // T+2
        bus.fpu_done   = 1'b1;
        bus.fpu_result = 32'hDEADBEEF;
        tick();                                       // T+3
        check("op3_start_drop", {31'h0, bus.fpu_start}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("op3_ack_hold", {31'h0, bus.fpu_ack}, 32'h1);
            check("op3_irq_low",  {31'h0, bus.cpu_irq}, 32'h0);
            tick();
        end                                           // T+7
        bus.fpu_done   = 1'b0;
        bus.fpu_result = 32'h0;
        check("op3_ack_r", {31'h0, bus.fpu_ack}, 32'h1);
        tick();                                       // R+1
        check("op3_ack_r1", {31'h0, bus.fpu_ack}, 32'h1);
        check("op3_irq_r1", {31'h0, bus.cpu_irq}, 32'h0);
        tick();                                       // R+2
        check("op3_ack_r2", {31'h0, bus.fpu_ack}, 32'h0);
        check("op3_irq_r2", {31'h0, bus.cpu_irq}, 32'h1);
        cpu_read(4'hC, "op3_res0", 8'hEF);
        cpu_read(4'hF, "op3_res3", 8'hDE);
        cpu_read(4'hB, "op3_cycles", 8'h07);
        cpu_write(4'hA, 8'h06);
        check("irq_cleared", {31'h0, bus.cpu_irq}, 32'h0);
        cpu_read(4'hA, "irq_en_kept", 8'h04);

        // Reset in the middle of WAIT_DONE
        cpu_write(4'h9, 8'h00);                       // T+1
        tick();                                       // T+2
        check("mid_start", {31'h0, bus.fpu_start}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_start", {31'h0, bus.fpu_start}, 32'h0);
        check("mid_rst_ack",   {31'h0, bus.fpu_ack},   32'h0);
        check("mid_rst_a",     bus.fpu_a,              32'h0);
        cpu_read(4'hA, "mid_rst_status", 8'h00);
        tick();
        check("mid_rst_idle", {31'h0, bus.fpu_start}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
